asgn_triple_accum: RTL and testbench
====================================

// Module: asgn_triple_accum
// PURPOSE
//  Downstream consumer of the assignment-expression datapath's three result words (x, y, z).
//  Accepts one triple per valid/ready beat and collects N_SAMPLES beats per frame.
//  For each frame it reports the running sum of x and the count of beats where x, y, z disagree.
//  Results are presented on a valid/ready output port. Sits between the combinational datapath and the result checker.
// PARAMETERS
//  W          32  width of each input word (unsigned)
//  N_SAMPLES  4   beats per frame, >=1
//  ACC_W      32  accumulator / out_sum width, >=W
// PORTS
//  clk        in   1                    rising-edge clock
//  rst_n      in   1                    synchronous active-low reset
//  in_valid   in   1                    input triple valid
//  in_ready   out  1                    block accepts a triple this cycle
//  in_x       in   W                    x result word
//  in_y       in   W                    y result word
//  in_z       in   W                    z result word
//  out_valid  out  1                    frame result valid
//  out_ready  in   1                    downstream accepts result
//  out_sum    out  ACC_W                sum of in_x over the frame
//  out_mism   out  $clog2(N_SAMPLES+1)  beats with (x!=y)||(y!=z)
//  out_ovf    out  1                    saturation occurred (ASGN_ACC_SAT_EN only, else tied 0)
// BEHAVIOUR
//  - One clock, clk; reset is rst_n, synchronous, active-low, sampled on the rising edge.
//  - Reset values: state=IDLE, out_valid=0, out_sum=0, out_mism=0, out_ovf=0, internal beat count=0.
//  - in_ready = (state!=DONE); decoded from registered state; no combinational path from out_ready.
//  - Beat accept = in_valid && in_ready.
//  - IDLE: on accept: acc=in_x, mism=neq, cnt=1.
//    Go to DONE if N_SAMPLES==1, else to ACCUM.
//  - ACCUM: on accept: acc=acc+in_x, mism=mism+neq, cnt=cnt+1.
//    Go to DONE when cnt+1==N_SAMPLES. No accept: hold all state.
//  - DONE: out_valid=1. out_sum/out_mism/out_ovf are stable while out_valid && !out_ready.
//    On out_ready: go to IDLE, clear acc/mism/cnt/ovf.
//    A new beat is not accepted in the same cycle; first beat of the next frame is accepted from IDLE.
//  - Latency: out_valid rises the cycle after the N-th beat is accepted.
//    Max throughput is N_SAMPLES beats per N_SAMPLES+1 cycles.
//  - Arithmetic: unsigned; in_x is zero-extended to ACC_W.
//  - neq = (in_x!=in_y)||(in_y!=in_z). out_mism never exceeds N_SAMPLES.
//  - in_valid while in DONE: ignored (in_ready=0); upstream must hold data.
//  - rst_n low mid-frame: partial frame is discarded and all outputs return to reset values next edge.
// CONFIGURATION
//  ASGN_ACC_SAT_EN defined:
//    - An add carry-out clamps acc to {ACC_W{1'b1}} and sets sticky out_ovf.
//    - acc stays clamped for the rest of the frame. out_ovf clears on the output handshake.
//  ASGN_ACC_SAT_EN undefined:
//    - acc wraps modulo 2^ACC_W.
//    - out_ovf is constant 0.
// STRUCTURE
//  Package asgn_acc_pkg:
//    - typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t
//    - function mism_w(n) = $clog2(n+1)
//  Sub-module asgn_tri_neq: combinational (a,b,c) -> neq, parameter W.
//  Top: FSM + accumulator + counters.
// TESTING
//  1. rst_n=0 for 2 cycles, in_valid=1 -> in_ready=1 only after release; out_valid=0, out_sum=0, out_mism=0.
//  2. N=4, four beats x=y=z=3,4,5,6 back-to-back
//     -> out_valid one cycle after 4th accept, out_sum=18, out_mism=0.
//  3. N=4, beat 2 has y=x+1, others equal, x=1,1,1,1 -> out_sum=4, out_mism=1.
//  4. Frame done, out_ready=0 for 5 cycles, in_valid=1
//     -> out_valid held, outputs stable, in_ready=0; out_ready=1 -> IDLE, next beat accepted the cycle after.
//  5. N=2, ACC_W=32, x=32'hFFFF_FFF0 then 32'h20
//     -> without macro out_sum=32'h10, out_ovf=0; with ASGN_ACC_SAT_EN out_sum=32'hFFFF_FFFF, out_ovf=1.
//  6. N=4, 2 beats x=7 accepted, then rst_n=0 for 1 cycle, then 4 beats x=1
//     -> out_sum=4, out_mism=0; no partial result ever emitted.

Source files
------------

// File: rtl/asgn_acc_pkg.sv
// Shared types and helpers for the triple accumulator slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package asgn_acc_pkg;

  // Frame FSM: IDLE waits for the first beat, ACCUM collects the rest,
  // DONE presents the result until the downstream takes it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Width needed to count 0..n inclusive.
  function automatic int mism_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/asgn_tri_neq.sv
// Flags a disagreement among three words: neq = (a!=b)||(b!=c).
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
//
// Ports:
//   a, b, c  in  W  words to compare
//   neq      out 1  high when the three words are not all equal
module asgn_tri_neq #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         neq
);

  assign neq = (a != b) || (b != c);

endmodule

// File: rtl/asgn_triple_accum.sv
// Collects N_SAMPLES (x,y,z) beats per frame; reports sum of x and count of mismatching beats.
// Latency: out_valid rises the cycle after the last beat of a frame is accepted.
// Backpressure: in_ready drops while a result waits in DONE; released one cycle after out handshake.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input beat handshake; in_x/in_y/in_z carry the triple
//   out_valid/out_ready        frame result handshake
//   out_sum   (ACC_W)          sum of in_x over the frame
//   out_mism  (mism_w(N))      beats where x,y,z were not all equal
//   out_ovf                    sticky accumulator saturation flag
// Build option: define ASGN_ACC_SAT_EN to saturate the accumulator and drive out_ovf;
// otherwise the accumulator wraps and out_ovf is tied low.
module asgn_triple_accum
  import asgn_acc_pkg::*;
#(
  parameter int W         = 32,
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [W-1:0]                   in_x,
  input  logic [W-1:0]                   in_y,
  input  logic [W-1:0]                   in_z,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               out_sum,
  output logic [mism_w(N_SAMPLES)-1:0]   out_mism,
  output logic                           out_ovf
);

  localparam int MW = mism_w(N_SAMPLES);
  // Count value held while the final beat of a frame is being accepted.
  localparam logic [MW-1:0] LAST_CNT = MW'(N_SAMPLES - 1);

  acc_state_t      state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [MW-1:0]    mism, mism_nxt;
  logic [MW-1:0]    cnt, cnt_nxt;
  logic             neq;
  logic             accept;
  logic [ACC_W-1:0] x_ext;

  asgn_tri_neq #(.W(W)) u_neq (
    .a   (in_x),
    .b   (in_y),
    .c   (in_z),
    .neq (neq)
  );

  assign x_ext = ACC_W'(in_x);

  // Gated by rst_n so nothing upstream sees a ready while reset is held.
  assign in_ready = rst_n && (state != DONE);
  assign accept   = in_valid && in_ready;

  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_mism  = mism;

`ifdef ASGN_ACC_SAT_EN
  logic             ovf, ovf_nxt;
  logic [ACC_W:0]   sum_ext;

  assign sum_ext = {1'b0, acc} + {1'b0, x_ext};
  assign out_ovf = ovf;
`else
  assign out_ovf = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    mism_nxt  = mism;
    cnt_nxt   = cnt;
`ifdef ASGN_ACC_SAT_EN
    ovf_nxt   = ovf;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = x_ext;
          mism_nxt  = MW'(neq);
          cnt_nxt   = MW'(1);
`ifdef ASGN_ACC_SAT_EN
          ovf_nxt   = 1'b0;
`endif
          state_nxt = (N_SAMPLES == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
`ifdef ASGN_ACC_SAT_EN
          // Once clamped, stay clamped until the frame is handed off.
          if (ovf || sum_ext[ACC_W]) begin
            acc_nxt = '1;
            ovf_nxt = 1'b1;
          end else begin
            acc_nxt = sum_ext[ACC_W-1:0];
          end
`else
          acc_nxt = acc + x_ext;
`endif
          mism_nxt = mism + MW'(neq);
          cnt_nxt  = cnt + MW'(1);
          if (cnt == LAST_CNT) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_nxt   = '0;
          mism_nxt  = '0;
          cnt_nxt   = '0;
`ifdef ASGN_ACC_SAT_EN
          ovf_nxt   = 1'b0;
`endif
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      mism  <= '0;
      cnt   <= '0;
`ifdef ASGN_ACC_SAT_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      mism  <= mism_nxt;
      cnt   <= cnt_nxt;
`ifdef ASGN_ACC_SAT_EN
      ovf   <= ovf_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_asgn_triple_accum.sv
// Directed bench for asgn_triple_accum: a 4-beat instance and a 2-beat instance.
// Latency: n/a (testbench).
// Backpressure: exercised by holding out_ready low with in_valid high.
module tb_asgn_triple_accum;

  localparam int W  = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // Instance A: N_SAMPLES = 4
  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [W-1:0]  a_x, a_y, a_z;
  logic [AW-1:0] a_out_sum;
  logic [2:0]    a_out_mism;

  // Instance B: N_SAMPLES = 2
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [W-1:0]  b_x, b_y, b_z;
  logic [AW-1:0] b_out_sum;
  logic [1:0]    b_out_mism;

  asgn_triple_accum #(.W(W), .N_SAMPLES(4), .ACC_W(AW)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_x      (a_x),
    .in_y      (a_y),
    .in_z      (a_z),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_mism  (a_out_mism),
    .out_ovf   (a_out_ovf)
  );

  asgn_triple_accum #(.W(W), .N_SAMPLES(2), .ACC_W(AW)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_x      (b_x),
    .in_y      (b_y),
    .in_z      (b_z),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_mism  (b_out_mism),
    .out_ovf   (b_out_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    a_in_valid = 1'b1;
    a_x = x;
    a_y = y;
    a_z = z;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_x = 32'd9; a_y = 32'd9; a_z = 32'd9; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_x = '0; b_y = '0; b_z = '0; b_out_ready = 1'b0;

    // 1. Reset held two cycles with in_valid high
    step();
    chk("rst_in_ready_c1", {63'd0, a_in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_out_sum", {32'd0, a_out_sum}, 64'd0);
    chk("rst_out_mism", {61'd0, a_out_mism}, 64'd0);
    chk("rst_out_ovf", {63'd0, a_out_ovf}, 64'd0);
    step();
    chk("rst_in_ready_c2", {63'd0, a_in_ready}, 64'd0);
    rst_n = 1'b1;
    a_in_valid = 1'b0;
    #1;
    chk("rel_in_ready", {63'd0, a_in_ready}, 64'd1);

    // 2. Four equal beats 3,4,5,6 back to back
    a_beat(32'd3, 32'd3, 32'd3);
    a_beat(32'd4, 32'd4, 32'd4);
    a_beat(32'd5, 32'd5, 32'd5);
    chk("t2_no_early_valid", {63'd0, a_out_valid}, 64'd0);
    a_beat(32'd6, 32'd6, 32'd6);
    a_in_valid = 1'b0;
    chk("t2_out_valid", {63'd0, a_out_valid}, 64'd1);
    chk("t2_out_sum", {32'd0, a_out_sum}, 64'd18);
    chk("t2_out_mism", {61'd0, a_out_mism}, 64'd0);
    chk("t2_in_ready_done", {63'd0, a_in_ready}, 64'd0);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk("t2_idle_valid", {63'd0, a_out_valid}, 64'd0);
    chk("t2_idle_sum_clr", {32'd0, a_out_sum}, 64'd0);
    chk("t2_idle_ready", {63'd0, a_in_ready}, 64'd1);

    // 3. x=1 for four beats, beat 2 has y=x+1
    a_beat(32'd1, 32'd1, 32'd1);
    a_beat(32'd1, 32'd2, 32'd1);
    a_beat(32'd1, 32'd1, 32'd1);
    a_beat(32'd1, 32'd1, 32'd1);
    chk("t3_out_valid", {63'd0, a_out_valid}, 64'd1);
    chk("t3_out_sum", {32'd0, a_out_sum}, 64'd4);
    chk("t3_out_mism", {61'd0, a_out_mism}, 64'd1);

    // 4. Result stalled 5 cycles while upstream keeps offering x=50
    a_in_valid = 1'b1; a_x = 32'd50; a_y = 32'd50; a_z = 32'd50;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", {63'd0, a_out_valid}, 64'd1);
      chk("t4_hold_sum", {32'd0, a_out_sum}, 64'd4);
      chk("t4_hold_mism", {61'd0, a_out_mism}, 64'd1);
      chk("t4_hold_in_ready", {63'd0, a_in_ready}, 64'd0);
    end
    a_out_ready = 1'b1;
    a_x = 32'd10; a_y = 32'd10; a_z = 32'd10;
    step();
    a_out_ready = 1'b0;
    chk("t4_idle_valid", {63'd0, a_out_valid}, 64'd0);
    chk("t4_idle_ready", {63'd0, a_in_ready}, 64'd1);
    // x=10 is accepted on this edge from IDLE, then 20,30,40 follow.
    step();
    a_beat(32'd20, 32'd20, 32'd20);
    a_beat(32'd30, 32'd30, 32'd30);
    chk("t4_no_early_valid", {63'd0, a_out_valid}, 64'd0);
    a_beat(32'd40, 32'd40, 32'd40);
    a_in_valid = 1'b0;
    chk("t4_next_valid", {63'd0, a_out_valid}, 64'd1);
    chk("t4_next_sum", {32'd0, a_out_sum}, 64'd100);
    chk("t4_next_mism", {61'd0, a_out_mism}, 64'd0);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;

    // 5. N=2 overflow: FFFF_FFF0 + 20
    b_in_valid = 1'b1; b_x = 32'hFFFF_FFF0; b_y = 32'hFFFF_FFF0; b_z = 32'hFFFF_FFF0;
    step();
    b_x = 32'h20; b_y = 32'h20; b_z = 32'h20;
    chk("t5_no_early_valid", {63'd0, b_out_valid}, 64'd0);
    step();
    b_in_valid = 1'b0;
    chk("t5_out_valid", {63'd0, b_out_valid}, 64'd1);
`ifdef ASGN_ACC_SAT_EN
    chk("t5_out_sum", {32'd0, b_out_sum}, 64'hFFFF_FFFF);
    chk("t5_out_ovf", {63'd0, b_out_ovf}, 64'd1);
`else
    chk("t5_out_sum", {32'd0, b_out_sum}, 64'h10);
    chk("t5_out_ovf", {63'd0, b_out_ovf}, 64'd0);
`endif
    chk("t5_out_mism", {62'd0, b_out_mism}, 64'd0);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("t5_ovf_cleared", {63'd0, b_out_ovf}, 64'd0);
    chk("t5_idle_valid", {63'd0, b_out_valid}, 64'd0);

    // 6. Partial frame of two x=7 beats discarded by a 1-cycle reset
    a_beat(32'd7, 32'd7, 32'd7);
    a_beat(32'd7, 32'd7, 32'd7);
    chk("t6_partial_no_valid", {63'd0, a_out_valid}, 64'd0);
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_valid", {63'd0, a_out_valid}, 64'd0);
    chk("t6_rst_sum", {32'd0, a_out_sum}, 64'd0);
    a_beat(32'd1, 32'd1, 32'd1);
    chk("t6_b1_no_valid", {63'd0, a_out_valid}, 64'd0);
    a_beat(32'd1, 32'd1, 32'd1);
    chk("t6_b2_no_valid", {63'd0, a_out_valid}, 64'd0);
    a_beat(32'd1, 32'd1, 32'd1);
    chk("t6_b3_no_valid", {63'd0, a_out_valid}, 64'd0);
    a_beat(32'd1, 32'd1, 32'd1);
    a_in_valid = 1'b0;
    chk("t6_out_valid", {63'd0, a_out_valid}, 64'd1);
    chk("t6_out_sum", {32'd0, a_out_sum}, 64'd4);
    chk("t6_out_mism", {61'd0, a_out_mism}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
